// File: rtl/univshift_pkg.sv
// Shared constants and types for the universal shift register command sequencer.
package univshift_pkg;

    localparam int USH_WIDTH = 4;

    // Register mode select encodings
    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    // Command opcodes; 110 and 111 are reserved and behave as NOP
    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_SHR  = 3'b010;
    localparam logic [2:0] OP_SHL  = 3'b011;
    localparam logic [2:0] OP_ROTR = 3'b100;
    localparam logic [2:0] OP_ROTL = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } ush_state_e;

    // A step count of zero encodes the full register width
    function automatic logic [2:0] step_count(input logic [1:0] n);
        return (n == 2'd0) ? 3'd4 : {1'b0, n};
    endfunction

    function automatic logic op_is_shift(input logic [2:0] op);
        return (op == OP_SHR) || (op == OP_SHL) || (op == OP_ROTR) || (op == OP_ROTL);
    endfunction

    function automatic logic op_is_right(input logic [2:0] op);
        return (op == OP_SHR) || (op == OP_ROTR);
    endfunction

endpackage

// File: rtl/univshift_ctrl_if.sv
// Command handshake between the bus/command logic and the shift sequencer.
interface univshift_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [1:0]       cmd_n;
    logic [WIDTH-1:0] cmd_data;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output cmd_valid, cmd_op, cmd_n, cmd_data,
        input  cmd_ready, done, result
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_n, cmd_data,
        output cmd_ready, done, result
    );
endinterface

// File: rtl/univshift_ctrl_step_cnt.sv
// Loadable 3-bit step down-counter; stops at zero rather than wrapping.
module univshift_step_cnt (
    input  logic       clk,
    input  logic       clear_b,
    input  logic       load,
    input  logic [2:0] load_val,
    input  logic       dec,
    output logic       zero,
    output logic       last
);
    logic [2:0] cnt_q;

    // Load on command acceptance, otherwise count down while stepping
    always_ff @(posedge clk or negedge clear_b) begin
        if (!clear_b) begin
            cnt_q <= 3'd0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != 3'd0)) begin
            cnt_q <= cnt_q - 3'd1;
        end
    end

    assign zero = (cnt_q == 3'd0);
    assign last = (cnt_q == 3'd1);

endmodule

// File: rtl/univshift_ctrl.sv
// Command sequencer driving a 4-bit universal shift register.
//
// state | meaning
// IDLE  | ready for a command, register held
// LOAD  | parallel load of the latched data, one cycle
// SHIFT | shift/rotate one position per cycle until the step count runs out
// DONE  | one-cycle completion pulse, result = register contents
module univshift_ctrl
    import univshift_pkg::*;
#(
    parameter int WIDTH = USH_WIDTH
) (
    input  logic             clk,
    input  logic             clear_b,
    univshift_ctrl_if.slave  cmd,
    input  logic             ser_in,
    output logic             ser_out,
    output logic [1:0]       s,
    output logic [WIDTH-1:0] I,
    output logic             S_l,
    output logic             S_r,
    input  logic [WIDTH-1:0] A
);
    ush_state_e       state_q, state_d;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] data_q;
    logic             accept;
    logic             cnt_zero;
    logic             cnt_last;

    assign accept = (state_q == ST_IDLE) && cmd.cmd_valid;

    // State register
    always_ff @(posedge clk or negedge clear_b) begin
        if (!clear_b) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture command fields on acceptance; reserved opcodes collapse to NOP
    always_ff @(posedge clk or negedge clear_b) begin
        if (!clear_b) begin
            op_q   <= OP_NOP;
            data_q <= '0;
        end else if (accept) begin
            op_q   <= (cmd.cmd_op > OP_ROTL) ? OP_NOP : cmd.cmd_op;
            data_q <= cmd.cmd_data;
        end
    end

    univshift_step_cnt u_step_cnt (
        .clk      (clk),
        .clear_b  (clear_b),
        .load     (accept),
        .load_val (step_count(cmd.cmd_n)),
        .dec      (state_q == ST_SHIFT),
        .zero     (cnt_zero),
        .last     (cnt_last)
    );

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (cmd.cmd_op == OP_LOAD) begin
                        state_d = ST_LOAD;
                    end else if (op_is_shift(cmd.cmd_op)) begin
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_LOAD:  state_d = ST_DONE;
            // The step taken this cycle is the final one when the count is 1
            ST_SHIFT: if (cnt_last || cnt_zero) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output decode; fill bits and ser_out pass through from ser_in / A
    always_comb begin
        cmd.cmd_ready = 1'b0;
        cmd.done      = 1'b0;
        cmd.result    = '0;
        s             = MODE_HOLD;
        I             = '0;
        S_l           = 1'b0;
        S_r           = 1'b0;
        ser_out       = 1'b0;
        case (state_q)
            ST_IDLE: cmd.cmd_ready = 1'b1;
            ST_LOAD: begin
                s = MODE_LOAD;
                I = data_q;
            end
            ST_SHIFT: begin
                if (op_is_right(op_q)) begin
                    s       = MODE_SHR;
                    ser_out = A[0];
                    S_r     = (op_q == OP_ROTR) ? A[0] : ser_in;
                end else begin
                    s       = MODE_SHL;
                    ser_out = A[WIDTH-1];
                    S_l     = (op_q == OP_ROTL) ? A[WIDTH-1] : ser_in;
                end
            end
            ST_DONE: begin
                cmd.done   = 1'b1;
                cmd.result = A;
            end
            default: ;
        endcase
    end

endmodule
